score_uart_tx: RTL

- Transmit end of the score path. The score counter produces two BCD digits (tens and ones) for the on-screen 7-segment renderer.
- This block serialises the same two digits over a UART TX line, so an external terminal or logger sees every score change.
- It is instantiated in the Pong top level alongside the score counter.
- Each report is one 4-byte ASCII frame: tens digit, ones digit, CR (0x0D), LF (0x0A). Format is 8N1, LSB first.

---
 rtl/pong_pkg.sv | 37 +++
 rtl/score_uart_tx_if.sv | 11 +
 rtl/uart_tx_byte.sv | 87 ++++++++
 rtl/score_uart_tx.sv | 84 ++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants, state enum and ASCII encoding for the score UART path
package pong_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Non-BCD nibbles show up as '?' so a corrupted score is visible on the terminal.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    logic [7:0] r;
    if (d <= 4'd9) r = ASCII_ZERO + {4'h0, d};
    else           r = ASCII_QMARK;
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] digits);
    logic [7:0] r;
    case (idx)
      2'd0:    r = digit_to_ascii(digits[7:4]);
      2'd1:    r = digit_to_ascii(digits[3:0]);
      2'd2:    r = ASCII_CR;
      default: r = ASCII_LF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/score_uart_tx_if.sv
// rtl/score_uart_tx_if.sv - score digits in, UART line and frame status out
interface score_uart_tx_if;
  logic [3:0] tens_digit;
  logic [3:0] ones_digit;
  logic       txd;
  logic       busy;
  logic       frame_done;

  modport master (output tens_digit, ones_digit, input txd, busy, frame_done);
  modport slave  (input tens_digit, ones_digit, output txd, busy, frame_done);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser with baud counter
module uart_tx_byte
  import pong_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          load;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A start presented on the last stop clock chains the next byte with no idle gap.
  always_comb begin
    state_next = state;
    txd        = 1'b1;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        txd = shreg[bit_idx];
        if (bit_end && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          done = 1'b1;
          if (start) begin
            load       = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      if (load) shreg <= data;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= 3'd0;
      end else if (bit_end) begin
        baud_cnt <= '0;
        if (state == DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_uart_tx.sv
// rtl/score_uart_tx.sv - reports every score change as an ASCII "TO\r\n" UART frame
module score_uart_tx
  import pong_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FRAME_BYTES  = 4
) (
  input  logic            Clock,
  input  logic            pointresetShot,
  score_uart_tx_if.slave  score
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  logic [7:0] cur;
  logic [7:0] prev;
  logic [7:0] snap;
  logic       pending;
  logic       busy_q;
  logic       frame_done_q;
  logic [1:0] byte_idx;
  logic       snap_take;
  logic       last_byte;
  logic       byte_start;
  logic       byte_done;
  logic [7:0] byte_data;
  logic       byte_txd;

  assign cur       = {score.tens_digit, score.ones_digit};
  assign snap_take = !busy_q && pending;
  assign last_byte = (byte_idx == LAST_IDX);

  // First byte comes straight from the live digits because snap is only loaded at this edge.
  always_comb begin
    byte_start = snap_take || (byte_done && !last_byte);
    byte_data  = busy_q ? frame_byte(byte_idx + 2'd1, snap) : frame_byte(2'd0, cur);
  end

  always_ff @(posedge Clock or posedge pointresetShot) begin
    if (pointresetShot) begin
      prev         <= 8'h00;
      snap         <= 8'h00;
      pending      <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_idx     <= 2'd0;
    end else begin
      prev         <= cur;
      frame_done_q <= 1'b0;
      if (snap_take) begin
        snap     <= cur;
        byte_idx <= 2'd0;
        busy_q   <= 1'b1;
        pending  <= 1'b0;
      end else begin
        if (cur != prev || cur != snap) pending <= 1'b1;
        if (byte_done) begin
          if (last_byte) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 2'd1;
          end
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .Clock (Clock),
    .reset (pointresetShot),
    .start (byte_start),
    .data  (byte_data),
    .txd   (byte_txd),
    .done  (byte_done)
  );

  assign score.txd        = byte_txd;
  assign score.busy       = busy_q;
  assign score.frame_done = frame_done_q;

endmodule
